// File: rtl/ps2_key_event.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into make/break events and
// derives edge-triggered flap/pause strobes with typematic repeats filtered out.
module ps2_key_event #(
  parameter logic [7:0] FLAP_CODE      = 8'h29,
  parameter logic [7:0] PAUSE_CODE     = 8'h4D,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       flap_pulse,
  output logic       pause_pulse,
  output logic       flap_held,
  output logic       err_pulse
);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          is_e0, is_f0, expired;
  logic          fire, fire_break, fire_ext, err_next;
  logic          flap_hit, pause_hit;
  logic          space_down_reg, p_down_reg;

  assign is_e0   = (code == 8'hE0);
  assign is_f0   = (code == 8'hF0);
  assign expired = (state_reg != IDLE) && !code_valid && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Counter stays 0 in IDLE and restarts on any byte; a byte in the expiry cycle wins.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    if (code_valid) begin
      case (state_reg)
        IDLE:    if (is_e0) state_next = GOT_E0;
                 else if (is_f0) state_next = GOT_F0;
        GOT_E0:  if (is_f0) state_next = GOT_E0F0;
                 else if (!is_e0) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE) begin
      if (expired) state_next = IDLE;
      else         cnt_next   = cnt_reg + CW'(1);
    end
  end

  always_comb begin
    fire       = 1'b0;
    fire_break = 1'b0;
    fire_ext   = 1'b0;
    err_next   = expired;
    if (code_valid) begin
      case (state_reg)
        IDLE:     fire = !is_e0 && !is_f0;
        GOT_E0: begin
          fire     = !is_e0 && !is_f0;
          fire_ext = 1'b1;
        end
        GOT_F0: begin
          fire       = !is_e0 && !is_f0;
          fire_break = 1'b1;
          err_next   = is_e0 || is_f0;
        end
        default: begin
          fire       = !is_e0 && !is_f0;
          fire_break = 1'b1;
          fire_ext   = 1'b1;
          err_next   = is_e0 || is_f0;
        end
      endcase
    end
  end

  assign flap_hit  = fire && !fire_ext && (code == FLAP_CODE);
  assign pause_hit = fire && !fire_ext && (code == PAUSE_CODE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid      <= 1'b0;
      evt_code       <= 8'h00;
      evt_break      <= 1'b0;
      evt_ext        <= 1'b0;
      flap_pulse     <= 1'b0;
      pause_pulse    <= 1'b0;
      err_pulse      <= 1'b0;
      space_down_reg <= 1'b0;
      p_down_reg     <= 1'b0;
    end else begin
      evt_valid   <= fire;
      err_pulse   <= err_next;
      flap_pulse  <= flap_hit && !fire_break && !space_down_reg;
      pause_pulse <= pause_hit && !fire_break && !p_down_reg;
      if (fire) begin
        evt_code  <= code;
        evt_break <= fire_break;
        evt_ext   <= fire_ext;
      end
      if (flap_hit)  space_down_reg <= !fire_break;
      if (pause_hit) p_down_reg     <= !fire_break;
    end
  end

  assign flap_held = space_down_reg;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event with a short prefix timeout.
module tb_ps2_key_event;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] code;
  logic       code_valid;
  logic       evt_valid, evt_break, evt_ext;
  logic [7:0] evt_code;
  logic       flap_pulse, pause_pulse, flap_held, err_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int ev_cnt, fp_cnt;

  ps2_key_event #(.FLAP_CODE(8'h29), .PAUSE_CODE(8'h4D), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_break(evt_break),
    .evt_ext(evt_ext), .flap_pulse(flap_pulse), .pause_pulse(pause_pulse),
    .flap_held(flap_held), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the outputs for this byte.
  task automatic send(input logic [7:0] b);
    code       = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    $display("send %02h: evt_valid=%0b code=%02h brk=%0b ext=%0b flap=%0b pause=%0b held=%0b err=%0b",
             b, evt_valid, evt_code, evt_break, evt_ext, flap_pulse, pause_pulse, flap_held, err_pulse);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_evt(input string tag, input int c, input int brk, input int ext);
    check({tag, "_valid"}, evt_valid, 1);
    check({tag, "_code"},  evt_code,  c);
    check({tag, "_break"}, evt_break, brk);
    check({tag, "_ext"},   evt_ext,   ext);
  endtask

  initial begin
    rst_n      = 1'b0;
    code       = 8'h00;
    code_valid = 1'b0;
    idle(3);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_code",  evt_code,  0);
    check("rst_flap_held", flap_held, 0);
    check("rst_err",       err_pulse, 0);
    rst_n = 1'b1;
    idle(1);

    // 1: Space press
    send(8'h29);
    check_evt("t1", 8'h29, 0, 0);
    check("t1_flap", flap_pulse, 1);
    check("t1_held", flap_held, 1);
    idle(1);
    check("t1_flap_clear", flap_pulse, 0);
    check("t1_hold_code", evt_code, 8'h29);

    // 2: release, then three back-to-back makes give one flap pulse
    send(8'hF0);
    check("t2_prefix_noevt", evt_valid, 0);
    send(8'h29);
    check_evt("t2_brk", 8'h29, 1, 0);
    check("t2_held0", flap_held, 0);
    ev_cnt = 0;
    fp_cnt = 0;
    code = 8'h29;
    code_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ev_cnt += int'(evt_valid);
      fp_cnt += int'(flap_pulse);
      if (i == 2) code_valid = 1'b0;
    end
    $display("repeat burst: events=%0d flap_pulses=%0d", ev_cnt, fp_cnt);
    check("t2_rep_events", ev_cnt, 3);
    check("t2_rep_flaps",  fp_cnt, 1);
    send(8'hF0);
    send(8'h29);
    check_evt("t2_brk2", 8'h29, 1, 0);
    check("t2_held_after_brk", flap_held, 0);
    send(8'h29);
    check("t2_reflap", flap_pulse, 1);

    // 3: extended make/break; extended 29 is not Space
    send(8'hE0);
    check("t3_e0_noevt", evt_valid, 0);
    send(8'h75);
    check_evt("t3_make", 8'h75, 0, 1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_evt("t3_brk", 8'h75, 1, 1);
    send(8'hE0);
    send(8'h29);
    check_evt("t3_ext29", 8'h29, 0, 1);
    check("t3_ext29_noflap", flap_pulse, 0);
    check("t3_held_kept", flap_held, 1);

    // 4: prefix timeout fires err once, then P press
    send(8'hF0);
    idle(T - 1);
    check("t4_err_early", err_pulse, 0);
    idle(1);
    check("t4_err", err_pulse, 1);
    idle(1);
    check("t4_err_once", err_pulse, 0);
    send(8'h4D);
    check_evt("t4_p", 8'h4D, 0, 0);
    check("t4_pause", pause_pulse, 1);

    // 5: illegal prefix sequence; byte in expiry cycle wins
    send(8'hF0);
    send(8'hE0);
    check("t5_err", err_pulse, 1);
    check("t5_noevt", evt_valid, 0);
    send(8'hF0);
    idle(T - 1);
    send(8'h29);
    check_evt("t5_expiry_brk", 8'h29, 1, 0);
    check("t5_expiry_noerr", err_pulse, 0);
    check("t5_held0", flap_held, 0);
    idle(1);
    check("t5_noerr_after", err_pulse, 0);

    // 6: reset discards a pending F0
    send(8'hF0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("t6_rst_held", flap_held, 0);
    send(8'h29);
    check_evt("t6_make", 8'h29, 0, 0);
    check("t6_flap", flap_pulse, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
